// File: rtl/queue_to_sb_sim.sv
// queue_to_sb_sim: switchboard receive endpoint. Polls a packet queue and
// presents packets on a valid/ready stream through a 2-entry buffer.
module queue_to_sb_sim #(
  parameter int unsigned VALID_MODE_DEFAULT = 0,
  parameter int unsigned DW                 = 416
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] data,
  output logic [31:0]   dest,
  output logic          last,
  output logic          valid,
  input  logic          ready
);
  localparam int unsigned SBDW = 416;
  localparam int unsigned QAW  = 8;
  localparam logic [QAW:0] QONE = (QAW+1)'(1);

  typedef enum logic [1:0] {
    VM_WAIT_READY = 2'd0,
    VM_FULL_RATE  = 2'd1,
    VM_RANDOM     = 2'd2
  } vmode_t;

  logic signed [31:0] id         = -32'sd1;
  vmode_t             valid_mode = vmode_t'(2'(VALID_MODE_DEFAULT));

  // In-module stand-in for the shared-memory queue; tx_send is its producer side.
  logic [SBDW-1:0] q_data [2**QAW];
  logic [31:0]     q_dest [2**QAW];
  logic            q_last [2**QAW];
  logic [QAW:0]    q_wr = '0;
  logic [QAW:0]    q_rd = '0;

  task init(input string uri);
    id = (uri.len() != 0) ? 32'sd0 : -32'sd1;
  endtask

  task set_valid_mode(input int unsigned v);
    valid_mode = vmode_t'(2'(v));
  endtask

  task tx_send(input logic [SBDW-1:0] d, input logic [31:0] de, input logic l);
    logic [QAW:0] level;
    level = q_wr - q_rd;
    if (!level[QAW]) begin
      q_data[q_wr[QAW-1:0]] = d;
      q_dest[q_wr[QAW-1:0]] = de;
      q_last[q_wr[QAW-1:0]] = l;
      q_wr = q_wr + QONE;
    end
  endtask

  logic [DW-1:0] ent_data [2] = '{default: '0};
  logic [31:0]   ent_dest [2] = '{default: '0};
  logic          ent_last [2] = '{default: 1'b0};
  logic          head    = 1'b0;
  logic          tail    = 1'b0;
  logic [1:0]    cnt     = '0;
  logic [DW-1:0] data_q  = '0;
  logic [31:0]   dest_q  = '0;
  logic          last_q  = 1'b0;
  logic          valid_q = 1'b0;
  logic [15:0]   lfsr    = 16'hace1;

  logic            hs, polling, push, present, head_n, show_ok;
  logic [1:0]      kept;
  logic [SBDW-1:0] q_word;

  // Only entries stored before this edge may be shown, so a fresh push
  // becomes visible one edge after it lands.
  always_comb begin
    hs      = valid_q & ready;
    polling = !rst && (id != -32'sd1) && (cnt != 2'd2 || hs);
    push    = polling && (q_wr != q_rd);
    kept    = cnt - {1'b0, hs};
    head_n  = head ^ hs;
    present = (kept != 2'd0);
    q_word  = q_data[q_rd[QAW-1:0]];
    case (valid_mode)
      VM_FULL_RATE: show_ok = 1'b1;
      VM_RANDOM:    show_ok = lfsr[0];
      default:      show_ok = ready;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
    end else begin
      if (push) begin
        ent_data[tail] <= q_word[DW-1:0];
        ent_dest[tail] <= q_dest[q_rd[QAW-1:0]];
        ent_last[tail] <= q_last[q_rd[QAW-1:0]];
        tail           <= ~tail;
      end
      cnt  <= kept + {1'b0, push};
      head <= head_n;
      if (!valid_q || hs) begin
        if (present) begin
          valid_q <= show_ok;
          data_q  <= ent_data[head_n];
          dest_q  <= ent_dest[head_n];
          last_q  <= ent_last[head_n];
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (push) q_rd <= q_rd + QONE;
  end

  assign data  = data_q;
  assign dest  = dest_q;
  assign last  = last_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_queue_to_sb_sim.sv
// Directed bench for queue_to_sb_sim: streaming, backpressure, valid modes
// and mid-stream reset against a scoreboard of sent packets.
module tb_queue_to_sb_sim;
  localparam int unsigned DW = 416;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic [31:0]   dest;
  logic          last;
  logic          valid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   de;
    logic          l;
  } pkt_t;

  pkt_t exp_q[$];

  queue_to_sb_sim #(
    .VALID_MODE_DEFAULT(0),
    .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .dest(dest),
    .last(last),
    .valid(valid),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [31:0] de, input logic l);
    pkt_t p;
    dut.tx_send(d, de, l);
    p = {d, de, l};
    exp_q.push_back(p);
  endtask

  function automatic logic [8:0] qlevel();
    return dut.q_wr - dut.q_rd;
  endfunction

  // pat: 0 ready always, 1 ready one cycle in four, 2 random ready
  task automatic run(input string tag, input int n, input int pat, input bit mode0,
                     input int budget, output int first, output int lastc);
    int   got = 0;
    bit   pv = 0, pr = 0, started = 0;
    pkt_t prev = '0, cur, e;
    first = -1;
    lastc = -1;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      cur = {data, dest, last};
      if (started) begin
        if (pv && !pr) check({tag, "_hold"}, {valid, cur}, {1'b1, prev});
        if (mode0 && !pv && valid) check({tag, "_rise"}, pr, 1);
      end
      started = 1;
      case (pat)
        0:       ready = 1'b1;
        1:       ready = (c % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (valid && ready) begin
        check({tag, "_avail"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "_pkt"}, cur, e);
        end
        if (first < 0) first = c;
        lastc = c;
        got++;
      end
      pv   = valid;
      pr   = ready;
      prev = cur;
    end
    @(negedge clk);
    ready = 1'b0;
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    int          f, l;
    logic [31:0] lf;

    rst   = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_dest", dest, 0);
    check("rst_last", last, 0);

    // Queued before init: must stay in the queue while id is unset.
    send(DW'(0), 32'h100, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("noinit_valid", valid, 0);
    check("noinit_qlevel", qlevel(), 1);

    for (int i = 1; i < 8; i++) send(DW'(i), 32'h100 + 32'(i), i == 7);
    dut.set_valid_mode(1);
    dut.init("sb://rx0");
    run("stream", 8, 0, 0, 40, f, l);
    check("stream_latency", f, 1);
    check("stream_b2b", l - f, 7);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) send({13{32'hb000_0000 + 32'(i)}}, 32'h200 + 32'(i), i == 4);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      check("bp_hold", {valid, data, dest, last}, {1'b1, exp_q[0]});
      @(negedge clk);
    end
    check("bp_qlevel", qlevel(), 3);
    run("bp", 5, 0, 0, 30, f, l);

    dut.set_valid_mode(0);
    for (int i = 0; i < 6; i++) send({13{32'hc0de_0000 + 32'(i)}}, 32'h300 + 32'(i), i == 5);
    run("m0", 6, 1, 1, 80, f, l);

    dut.set_valid_mode(2);
    lf = 32'h1;
    for (int i = 0; i < 200; i++) begin
      lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
      send({13{lf}}, lf ^ 32'h5555_0000, lf[0]);
    end
    run("m2", 200, 2, 0, 4000, f, l);

    dut.set_valid_mode(1);
    send({13{32'haaaa_0001}}, 32'h400, 1'b0);
    send({13{32'haaaa_0002}}, 32'h401, 1'b0);
    send({13{32'haaaa_0003}}, 32'h402, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_valid", valid, 1);
    check("mid_data", data, exp_q[0].d);
    check("mid_qlevel", qlevel(), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", data, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    run("mid", 1, 0, 0, 10, f, l);
    check("mid_qlevel_end", qlevel(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
